// File: rtl/pomo_seq_gen.sv
// Pomodoro work/rest sequencer: owns the phase countdown, cycle counting and auto-start.
// Optional LONG break phase is enabled by defining POMO_LONG_BREAK_EN.
module pomo_seq_gen #(
  parameter int TW        = 8,
  parameter int CYCLES    = 4,
  parameter int CW        = 3,
  parameter int WORK_DEF  = 25,
  parameter int SHORT_LEN = 5,
  parameter int LONG_LEN  = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tick,
  input  logic          key_load,
  input  logic          key_ss,
  input  logic          key_mode,
  input  logic          auto_en,
  input  logic [TW-1:0] set_val,
  output logic [1:0]    state,
  output logic [1:0]    phase,
  output logic [TW-1:0] remain,
  output logic [CW-1:0] cycle_cnt,
  output logic          cnt_en,
  output logic          time_out,
  output logic          sess_done
);

  typedef enum logic [1:0] {ST_READY, ST_RUN, ST_PAUSE, ST_SET} state_e;
  typedef enum logic [1:0] {PH_WORK, PH_SHORT, PH_LONG, PH_BAD} phase_e;

  state_e        state_q, state_d;
  phase_e        phase_q, phase_d;
  logic [TW-1:0] remain_q, remain_d;
  logic [TW-1:0] work_len_q, work_len_d;
  logic [CW-1:0] cycle_q, cycle_d;
  logic          cnt_en_q;
  logic          time_out_q, time_out_d;
  logic          sess_done_q, sess_done_d;
  logic          auto_pend_q, auto_pend_d;

  logic [TW-1:0] set_clamped;
  logic [CW-1:0] cnt_inc;

  function automatic logic [TW-1:0] len_of(input phase_e p, input logic [TW-1:0] wl);
    case (p)
      PH_SHORT: len_of = TW'(SHORT_LEN);
      PH_LONG:  len_of = TW'(LONG_LEN);
      default:  len_of = wl;
    endcase
  endfunction

  assign set_clamped = (set_val == '0) ? TW'(1) : set_val;
  // Saturate so a WORK following a skipped LONG cannot push the count past CYCLES.
  assign cnt_inc = (cycle_q >= CW'(CYCLES)) ? CW'(CYCLES) : cycle_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    remain_d    = remain_q;
    work_len_d  = work_len_q;
    cycle_d     = cycle_q;
    time_out_d  = 1'b0;
    sess_done_d = 1'b0;
    auto_pend_d = auto_pend_q;

    case (state_q)
      ST_READY: begin
        if (key_load) begin
          phase_d     = (phase_q == PH_WORK) ? PH_SHORT : PH_WORK;
          remain_d    = len_of(phase_d, work_len_q);
          auto_pend_d = 1'b0;
        end else if (key_ss || auto_pend_q) begin
          state_d     = ST_RUN;
          auto_pend_d = 1'b0;
        end
      end
      ST_RUN: begin
        if (key_ss) begin
          state_d = ST_PAUSE;
        end else if (tick) begin
          if (remain_q > TW'(1)) begin
            remain_d = remain_q - 1'b1;
          end else begin
            state_d     = ST_READY;
            time_out_d  = 1'b1;
            auto_pend_d = auto_en;
            if (phase_q == PH_WORK) begin
              cycle_d = cnt_inc;
`ifdef POMO_LONG_BREAK_EN
              phase_d = (cnt_inc == CW'(CYCLES)) ? PH_LONG : PH_SHORT;
`else
              phase_d = PH_SHORT;
              if (cnt_inc == CW'(CYCLES)) begin
                cycle_d     = '0;
                sess_done_d = 1'b1;
              end
`endif
            end else begin
              phase_d = PH_WORK;
              if (phase_q == PH_LONG) begin
                cycle_d     = '0;
                sess_done_d = 1'b1;
                auto_pend_d = 1'b0;
              end
            end
            remain_d = len_of(phase_d, work_len_q);
          end
        end
      end
      ST_PAUSE: begin
        if (key_load) begin
          state_d     = ST_READY;
          phase_d     = (phase_q == PH_WORK) ? PH_SHORT : PH_WORK;
          remain_d    = len_of(phase_d, work_len_q);
          auto_pend_d = 1'b0;
          if (phase_q == PH_LONG) cycle_d = '0;
        end else if (key_ss) begin
          state_d = ST_RUN;
        end else if (key_mode) begin
          state_d = ST_SET;
        end
      end
      default: begin
        work_len_d = set_clamped;
        remain_d   = set_clamped;
        if (key_mode) begin
          state_d = ST_READY;
          phase_d = PH_WORK;
        end
      end
    endcase

    if (phase_q == PH_BAD) begin
      state_d     = ST_READY;
      phase_d     = PH_WORK;
      remain_d    = TW'(WORK_DEF);
      work_len_d  = TW'(WORK_DEF);
      cycle_d     = '0;
      time_out_d  = 1'b0;
      sess_done_d = 1'b0;
      auto_pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_READY;
      phase_q     <= PH_WORK;
      remain_q    <= TW'(WORK_DEF);
      work_len_q  <= TW'(WORK_DEF);
      cycle_q     <= '0;
      cnt_en_q    <= 1'b0;
      time_out_q  <= 1'b0;
      sess_done_q <= 1'b0;
      auto_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      remain_q    <= remain_d;
      work_len_q  <= work_len_d;
      cycle_q     <= cycle_d;
      cnt_en_q    <= (state_d == ST_RUN);
      time_out_q  <= time_out_d;
      sess_done_q <= sess_done_d;
      auto_pend_q <= auto_pend_d;
    end
  end

  assign state     = state_q;
  assign phase     = phase_q;
  assign remain    = remain_q;
  assign cycle_cnt = cycle_q;
  assign cnt_en    = cnt_en_q;
  assign time_out  = time_out_q;
  assign sess_done = sess_done_q;

endmodule

// File: tb/tb_pomo_seq_gen.sv
// Directed self-checking bench for pomo_seq_gen (TW=8, CYCLES=2, WORK_DEF=3, SHORT_LEN=2, LONG_LEN=4).
module tb_pomo_seq_gen;

  localparam logic [1:0] RD = 2'd0, RU = 2'd1, PA = 2'd2, SE = 2'd3;
  localparam logic [1:0] W = 2'd0, S = 2'd1, L = 2'd2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick = 1'b0, key_load = 1'b0, key_ss = 1'b0, key_mode = 1'b0, auto_en = 1'b0;
  logic [7:0] set_val = 8'd3;
  logic [1:0] state, phase;
  logic [7:0] remain;
  logic [2:0] cycle_cnt;
  logic       cnt_en, time_out, sess_done;
  logic [17:0] obs;
  logic [17:0] exp_v;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  pomo_seq_gen #(.TW(8), .CYCLES(2), .CW(3), .WORK_DEF(3), .SHORT_LEN(2), .LONG_LEN(4)) dut (
    .clk(clk), .rst(rst), .tick(tick), .key_load(key_load), .key_ss(key_ss),
    .key_mode(key_mode), .auto_en(auto_en), .set_val(set_val), .state(state),
    .phase(phase), .remain(remain), .cycle_cnt(cycle_cnt), .cnt_en(cnt_en),
    .time_out(time_out), .sess_done(sess_done)
  );

  assign obs = {state, phase, remain, cycle_cnt, cnt_en, time_out, sess_done};

  // Expected observation vector; cnt_en follows from the state being RUN.
  function automatic logic [17:0] pk(input logic [1:0] st, input logic [1:0] ph,
                                     input logic [7:0] rm, input logic [2:0] cc,
                                     input logic to, input logic sd);
    pk = {st, ph, rm, cc, (st == RU), to, sd};
  endfunction

  task automatic step(input logic l, input logic s, input logic m, input logic t);
    key_load = l; key_ss = s; key_mode = m; tick = t;
    @(posedge clk); #1;
    key_load = 1'b0; key_ss = 1'b0; key_mode = 1'b0; tick = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; step(0,0,0,0); step(0,0,0,0);
    exp_v = pk(RD,W,3,0,0,0); tests++;
    if (obs !== exp_v) begin fails++; $display("FAIL reset got=%h exp=%h", obs, exp_v); end
    rst = 1'b0;
  endtask

  task automatic test_work_expiry;
    step(0,1,0,0);
    exp_v = pk(RU,W,3,0,0,0); tests++;
    if (obs !== exp_v) begin fails++; $display("FAIL start got=%h exp=%h", obs, exp_v); end
    step(1,0,0,0);
    exp_v = pk(RU,W,3,0,0,0); tests++;
    if (obs !== exp_v) begin fails++; $display("FAIL run_load_ignored got=%h exp=%h", obs, exp_v); end
    for (int i = 1; i <= 2; i++) begin
      step(0,0,0,1);
      exp_v = pk(RU,W,8'(3-i),0,0,0); tests++;
      if (obs !== exp_v) begin fails++; $display("FAIL work_count%0d got=%h exp=%h", i, obs, exp_v); end
    end
    step(0,0,0,1);
    exp_v = pk(RD,S,2,1,1,0); tests++;
    if (obs !== exp_v) begin fails++; $display("FAIL work_expire got=%h exp=%h", obs, exp_v); end
    step(0,0,0,0);
    exp_v = pk(RD,S,2,1,0,0); tests++;
    if (obs !== exp_v) begin fails++; $display("FAIL timeout_one_cycle got=%h exp=%h", obs, exp_v); end
    step(0,0,1,0);
    exp_v = pk(RD,S,2,1,0,0); tests++;
    if (obs !== exp_v) begin fails++; $display("FAIL ready_mode_ignored got=%h exp=%h", obs, exp_v); end
    $display("[TB] work expiry done");
  endtask

  task automatic test_pause_set;
    step(1,0,0,0); step(0,1,0,0); step(0,0,0,1);
    exp_v = pk(RU,W,2,1,0,0); tests++;
    if (obs !== exp_v) begin fails++; $display("FAIL run_w2 got=%h exp=%h", obs, exp_v); end
    step(0,1,0,1);
    exp_v = pk(PA,W,2,1,0,0); tests++;
    if (obs !== exp_v) begin fails++; $display("FAIL pause_tick_ignored got=%h exp=%h", obs, exp_v); end
    step(0,0,1,0);
    exp_v = pk(SE,W,2,1,0,0); tests++;
    if (obs !== exp_v) begin fails++; $display("FAIL enter_set got=%h exp=%h", obs, exp_v); end
    set_val = 8'd0;
    step(0,1,0,0);
    exp_v = pk(SE,W,1,1,0,0); tests++;
    if (obs !== exp_v) begin fails++; $display("FAIL set_clamp got=%h exp=%h", obs, exp_v); end
    step(0,0,1,0);
    exp_v = pk(RD,W,1,1,0,0); tests++;
    if (obs !== exp_v) begin fails++; $display("FAIL exit_set got=%h exp=%h", obs, exp_v); end
    $display("[TB] pause/set done");
  endtask

  task automatic test_abandon;
    step(0,1,0,0); step(0,1,0,0);
    exp_v = pk(PA,W,1,1,0,0); tests++;
    if (obs !== exp_v) begin fails++; $display("FAIL pause_w1 got=%h exp=%h", obs, exp_v); end
    step(1,0,0,0);
    exp_v = pk(RD,S,2,1,0,0); tests++;
    if (obs !== exp_v) begin fails++; $display("FAIL abandon_work got=%h exp=%h", obs, exp_v); end
    step(0,1,0,0); step(0,1,0,0); step(0,1,0,0);
    exp_v = pk(RU,S,2,1,0,0); tests++;
    if (obs !== exp_v) begin fails++; $display("FAIL resume got=%h exp=%h", obs, exp_v); end
    step(0,1,0,0); step(0,0,1,0);
    set_val = 8'd3;
    step(0,0,0,0);
    exp_v = pk(SE,S,3,1,0,0); tests++;
    if (obs !== exp_v) begin fails++; $display("FAIL set_three got=%h exp=%h", obs, exp_v); end
    step(0,0,1,0);
    exp_v = pk(RD,W,3,1,0,0); tests++;
    if (obs !== exp_v) begin fails++; $display("FAIL exit_set_w3 got=%h exp=%h", obs, exp_v); end
    $display("[TB] abandon done");
  endtask

  task automatic test_priority;
    step(1,1,0,0);
    exp_v = pk(RD,S,2,1,0,0); tests++;
    if (obs !== exp_v) begin fails++; $display("FAIL load_over_ss got=%h exp=%h", obs, exp_v); end
    step(1,0,0,0);
    exp_v = pk(RD,W,3,1,0,0); tests++;
    if (obs !== exp_v) begin fails++; $display("FAIL toggle_back got=%h exp=%h", obs, exp_v); end
    $display("[TB] priority done");
  endtask

  task automatic test_cycle_wrap;
    step(0,1,0,0); step(0,0,0,1); step(0,0,0,1); step(0,0,0,1);
`ifdef POMO_LONG_BREAK_EN
    exp_v = pk(RD,L,4,2,1,0); tests++;
    if (obs !== exp_v) begin fails++; $display("FAIL enter_long got=%h exp=%h", obs, exp_v); end
    step(0,1,0,0); step(0,0,0,1); step(0,0,0,1); step(0,0,0,1); step(0,0,0,1);
    exp_v = pk(RD,W,3,0,1,1); tests++;
    if (obs !== exp_v) begin fails++; $display("FAIL long_end got=%h exp=%h", obs, exp_v); end
`else
    exp_v = pk(RD,S,2,0,1,1); tests++;
    if (obs !== exp_v) begin fails++; $display("FAIL session_wrap got=%h exp=%h", obs, exp_v); end
`endif
    $display("[TB] cycle wrap done");
  endtask

  task automatic test_auto;
    rst = 1'b1; step(0,0,0,0); rst = 1'b0;
    auto_en = 1'b1;
    step(0,1,0,0); step(0,0,0,1); step(0,0,0,1); step(0,0,0,1);
    exp_v = pk(RD,S,2,1,1,0); tests++;
    if (obs !== exp_v) begin fails++; $display("FAIL auto_w_end got=%h exp=%h", obs, exp_v); end
    step(0,0,0,0);
    exp_v = pk(RU,S,2,1,0,0); tests++;
    if (obs !== exp_v) begin fails++; $display("FAIL auto_start_s got=%h exp=%h", obs, exp_v); end
    step(0,0,0,1); step(0,0,0,1);
    exp_v = pk(RD,W,3,1,1,0); tests++;
    if (obs !== exp_v) begin fails++; $display("FAIL auto_s_end got=%h exp=%h", obs, exp_v); end
    step(0,0,0,0);
    exp_v = pk(RU,W,3,1,0,0); tests++;
    if (obs !== exp_v) begin fails++; $display("FAIL auto_start_w got=%h exp=%h", obs, exp_v); end
    step(0,0,0,1); step(0,0,0,1); step(0,0,0,1);
`ifdef POMO_LONG_BREAK_EN
    exp_v = pk(RD,L,4,2,1,0); tests++;
    if (obs !== exp_v) begin fails++; $display("FAIL auto_to_long got=%h exp=%h", obs, exp_v); end
    step(0,0,0,0);
    for (int i = 1; i <= 3; i++) step(0,0,0,1);
    exp_v = pk(RU,L,1,2,0,0); tests++;
    if (obs !== exp_v) begin fails++; $display("FAIL auto_long_run got=%h exp=%h", obs, exp_v); end
    step(0,0,0,1);
    exp_v = pk(RD,W,3,0,1,1); tests++;
    if (obs !== exp_v) begin fails++; $display("FAIL auto_long_end got=%h exp=%h", obs, exp_v); end
    step(0,0,0,0); step(0,0,0,0);
    exp_v = pk(RD,W,3,0,0,0); tests++;
    if (obs !== exp_v) begin fails++; $display("FAIL no_auto_after_long got=%h exp=%h", obs, exp_v); end
`else
    exp_v = pk(RD,S,2,0,1,1); tests++;
    if (obs !== exp_v) begin fails++; $display("FAIL auto_wrap got=%h exp=%h", obs, exp_v); end
    step(0,0,0,0);
    exp_v = pk(RU,S,2,0,0,0); tests++;
    if (obs !== exp_v) begin fails++; $display("FAIL auto_after_wrap got=%h exp=%h", obs, exp_v); end
`endif
    auto_en = 1'b0;
    $display("[TB] auto sequence done");
  endtask

  task automatic test_reset_mid;
    rst = 1'b1; step(0,0,0,0); rst = 1'b0;
    step(0,1,0,0); step(0,0,0,1); step(0,0,0,1);
    exp_v = pk(RU,W,1,0,0,0); tests++;
    if (obs !== exp_v) begin fails++; $display("FAIL pre_reset got=%h exp=%h", obs, exp_v); end
    rst = 1'b1;
    step(0,0,0,1);
    exp_v = pk(RD,W,3,0,0,0); tests++;
    if (obs !== exp_v) begin fails++; $display("FAIL reset_override got=%h exp=%h", obs, exp_v); end
    rst = 1'b0;
    step(0,0,0,0);
    exp_v = pk(RD,W,3,0,0,0); tests++;
    if (obs !== exp_v) begin fails++; $display("FAIL post_reset_idle got=%h exp=%h", obs, exp_v); end
    $display("[TB] mid-run reset done");
  endtask

  initial begin
    test_reset();
    test_work_expiry();
    test_pause_set();
    test_abandon();
    test_priority();
    test_cycle_wrap();
    test_auto();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pomo_seq_gen.md
Name: pomo_seq_gen

Overview:
- Parametrised work/rest sequencer for the pomodoro timer, successor to the fixed work/rest state controller.
- Owns the countdown internally: counts `tick` pulses, sequences WORK → SHORT → … → LONG break, counts cycles and optionally auto-starts the next phase.
- Sits between the key debouncers / 1 Hz tick generator and the display driver.

Parameters:
- TW, 8, width of time values (ticks).
- CYCLES, 4, number of completed WORK phases before a LONG break; legal range 1..2^CW-1.
- CW, 3, width of cycle_cnt.
- WORK_DEF, 25, reset/default WORK length in ticks; must be ≥1.
- SHORT_LEN, 5, SHORT break length in ticks; must be ≥1.
- LONG_LEN, 15, LONG break length in ticks; must be ≥1.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- tick  in  1  one-cycle time-unit pulse.
- key_load  in  1  one-cycle pulse: skip / toggle phase.
- key_ss  in  1  one-cycle pulse: start/stop.
- key_mode  in  1  one-cycle pulse: enter/exit SET.
- auto_en  in  1  level; enables auto-start of the next phase.
- set_val  in  TW  new WORK length, sampled in SET.
- state  out  2  READY=0, RUN=1, PAUSE=2, SET=3.
- phase  out  2  WORK=0, SHORT=1, LONG=2.
- remain  out  TW  ticks remaining in the current phase.
- cycle_cnt  out  CW  WORK phases completed in the current session.
- cnt_en  out  1  high while state==RUN.
- time_out  out  1  one-cycle pulse on natural phase expiry.
- sess_done  out  1  one-cycle pulse when a LONG break completes.

Behaviour:
- All outputs are registered and update on the clk rising edge.
- Reset values: state=READY, phase=WORK, remain=WORK_DEF, work_len=WORK_DEF, cycle_cnt=0, cnt_en=0, time_out=0, sess_done=0, auto_pend=0.
- Reset asserted mid-operation overrides everything in that cycle.

Phase lengths:
- WORK uses internal work_len; SHORT and LONG use their parameters.
- When any phase is entered, remain is loaded with that phase's length.
- set_val==0 is clamped to 1; remain never reaches 0 in READY.

READY:
- key_load: toggle the phase without a count. WORK→SHORT; SHORT or LONG→WORK. remain is reloaded; cycle_cnt is unchanged; auto_pend is cleared.
- Otherwise, key_ss or auto_pend: go to RUN and clear auto_pend.
- key_mode is ignored.
- Priority: key_load > key_ss.

RUN:
- key_ss: go to PAUSE. A tick in the same cycle is ignored.
- tick with remain>1: remain decrements by 1.
- tick with remain==1 (expiry):
  - time_out=1 for one cycle; state goes to READY.
  - Expiring WORK: cycle_cnt+1. If the new value equals CYCLES, the next phase is LONG, otherwise SHORT.
  - Expiring SHORT: next phase is WORK.
  - Expiring LONG: next phase is WORK, cycle_cnt=0, sess_done=1 in the same cycle as time_out.
  - auto_pend is set to auto_en, except after LONG, where it is set to 0.
  - An auto-start leaves READY on the next cycle, so READY is visible for exactly 1 cycle.
- key_load and key_mode are ignored.

PAUSE:
- remain is frozen.
- key_load: abandon the phase and go to READY with the next phase selected as for an expiry, except:
  - cycle_cnt is not incremented; an abandoned WORK goes to SHORT;
  - time_out and sess_done stay low;
  - abandoning LONG still clears cycle_cnt.
- Otherwise, key_ss: go to RUN.
- Otherwise, key_mode: go to SET.
- Priority: key_load > key_ss > key_mode.

SET:
- Every cycle, work_len ← clamp(set_val); remain displays work_len.
- key_mode: go to READY with phase=WORK, remain=work_len; cycle_cnt is unchanged.
- All other keys are ignored.

Arithmetic and default case:
- Counters are unsigned. cycle_cnt never exceeds CYCLES.
- Illegal state or phase encodings recover to the reset values on the next clock.

Optional Feature:
- Macro: POMO_LONG_BREAK_EN.
- Defined: behaviour exactly as described above.
- Undefined:
  - LONG is never entered.
  - A WORK expiry that brings cycle_cnt to CYCLES sets cycle_cnt=0, pulses sess_done together with time_out, and selects SHORT.
  - auto_pend follows auto_en, with no forced stop.
  - LONG_LEN is unused.

Test Plan (TW=8, CYCLES=2, WORK_DEF=3, SHORT_LEN=2, LONG_LEN=4, macro defined):
- Reset, then key_ss, then 3 ticks → remain 3,2,1; on the 3rd tick time_out pulses 1 cycle, phase=SHORT, remain=2, cycle_cnt=1, state=READY.
- auto_en=1, one key_ss, ticks only → sequence WORK(3), SHORT(2), WORK(3), LONG(4). sess_done and time_out pulse together at LONG end; cycle_cnt=0; state holds READY/WORK with no auto-start.
- RUN WORK at remain=2: key_ss and tick in the same cycle → state=PAUSE, remain stays 2. Then key_mode, set_val=0, key_mode → READY, WORK, remain=1.
- PAUSE in WORK with cycle_cnt=1: key_load → READY, SHORT, remain=2, cycle_cnt=1, no time_out.
- READY/WORK: key_load and key_ss in the same cycle → phase=SHORT, state=READY. rst asserted during RUN at remain=1 with a tick → all outputs take their reset values.
- Macro undefined: 2 WORK expiries → the second pulses sess_done, cycle_cnt=0, phase=SHORT.
